issue_queue: RTL
================

Name: issue_queue

Overview:
- 16-entry out-of-order issue queue that sits directly upstream of the wakeup/select priority encoder.
- Accepts dispatched instructions and tracks readiness of two source operands per entry. Snoops result-tag broadcasts to wake up waiting operands.
- Drives a 16-bit request vector to the selector and consumes its issue/grant_index reply. Frees the granted entry and registers its payload toward execute.

Parameters:
- DEPTH, 16, number of entries; fixed to match the 16-bit selector, 4-bit index.
- TAG_W, 6, physical register tag width.
- PAYLOAD_W, 32, opaque instruction payload (opcode/imm/dest) carried through.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- flush_IN  in  1  synchronous; invalidates all entries next edge.
- dispatch_valid_IN  in  1  dispatch offers an instruction.
- dispatch_ready_OUT  out  1  queue has a free entry (combinational from valid bits).
- dispatch_payload_IN  in  PAYLOAD_W  instruction payload.
- dispatch_src1_tag_IN / dispatch_src2_tag_IN  in  TAG_W each  source tags.
- dispatch_src1_rdy_IN / dispatch_src2_rdy_IN  in  1 each  operand already available at dispatch.
- wb_valid_IN  in  2  per-lane broadcast valid (two result buses).
- wb_tag_IN  in  2*TAG_W  lane0 in [TAG_W-1:0], lane1 above.
- request_OUT  out  16  entry i valid and both sources ready; feeds selector request_IN.
- Issue_IN  in  1  selector granted some entry.
- grant_index_IN  in  4  index of granted entry.
- exec_stall_IN  in  1  execute cannot accept; hold issue register.
- issue_valid_OUT  out  1  registered issue strobe.
- issue_payload_OUT  out  PAYLOAD_W  registered payload of issued entry.
- count_OUT  out  5  occupied entries, 0..16.

Behaviour:
- Reset (async, RESET=0): all entry valid bits 0, issue_valid_OUT 0, issue_payload_OUT 0, count_OUT 0. request_OUT is therefore 0.
- Entry state: valid, payload, src1 tag/rdy, src2 tag/rdy.
- Dispatch:
  - Fires when dispatch_valid_IN && dispatch_ready_OUT && !flush_IN.
  - Writes the lowest-index free entry.
  - dispatch_ready_OUT = any entry invalid, evaluated on pre-edge state. An entry freed by issue this cycle is not reusable until the next cycle.
- Wakeup:
  - Each edge, for every valid entry and each lane with wb_valid_IN set, a tag match sets the corresponding rdy bit.
  - Same-cycle bypass: a dispatched source is marked ready if its rdy input is 1 or its tag matches either valid lane this cycle.
- Request: request_OUT[i] = valid[i] & src1_rdy[i] & src2_rdy[i] & !exec_stall_IN. Purely from registered state; wakeup affects requests the cycle after broadcast.
- Issue (when Issue_IN && !exec_stall_IN):
  - Next edge: entry grant_index_IN is cleared.
  - issue_payload_OUT <= its payload; issue_valid_OUT <= 1.
- No issue: issue_valid_OUT <= 0 unless stalled.
- exec_stall_IN=1: issue_valid_OUT/payload hold their values; no entry is freed; request_OUT is forced to 0.
- Issue_IN with a grant to an invalid entry is illegal; design asserts it in simulation and ignores it.
- count_OUT: +1 on dispatch, -1 on issue; both in the same cycle leaves it unchanged. The range 0..16 never wraps.
- Full (count 16): dispatch_ready_OUT=0; a dispatch offer is ignored with no state change.
- Empty: request_OUT=0; selector returns Issue_IN=0.
- flush_IN:
  - Highest priority: all valid bits <= 0, count_OUT <= 0, issue_valid_OUT <= 0.
  - Simultaneous dispatch, issue and wakeup are discarded.
- Reset mid-operation: immediate clear regardless of clock. No partial issue is emitted after deassertion.
- Latency: dispatch with ready operands at edge N gives request at N+1 and issue_valid_OUT at N+2.

Decomposition:
- Shared package: TAG_W, PAYLOAD_W, DEPTH constants and an entry struct/typedef {valid, payload, src tags, rdy bits}.
- Natural sub-module: iq_free_finder, a lowest-free-index priority encoder (16-in, 4-bit index plus any_free). It mirrors the selector's priority chain on inverted valid bits.
- Wakeup compare logic is instantiated inline per entry.

Test Plan:
- Reset, then dispatch one instr with src1_rdy=src2_rdy=1 at cycle 1 -> request_OUT=16'h0001 at cycle 2; with selector model granting index 0, issue_valid_OUT=1 and payload matches at cycle 3, count_OUT back to 0.
- Dispatch tags 5/7 not ready into entry 0; broadcast lane0 tag 5 at cycle 3 and lane1 tag 7 at cycle 5 -> request_OUT[0] stays 0 until cycle 6, then 1.
- Dispatch src1 tag 9 not ready while lane1 broadcasts tag 9 in the same cycle -> src1 marked ready; request_OUT bit set next cycle.
- Fill 16 entries -> count_OUT=16, dispatch_ready_OUT=0, a 17th offer is ignored. Issue entry 3 -> next dispatch lands in entry 3, the cycle after the free.
- Hold exec_stall_IN=1 for 3 cycles with ready entries -> request_OUT=0, issue_valid_OUT/payload held, count unchanged. Release -> issue resumes at the lowest ready index.
- Assert flush_IN together with dispatch and issue -> next cycle count_OUT=0, request_OUT=0, issue_valid_OUT=0. Async RESET low mid-stream clears all outputs without waiting for CLK.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared constants, entry layout and tag-compare helpers for the issue queue.
package issue_queue_pkg;

    localparam int DEPTH     = 16;
    localparam int TAG_W     = 6;
    localparam int PAYLOAD_W = 32;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 5;
    localparam int LANES     = 2;

    // One source operand: physical tag plus availability.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rdy;
    } iq_src_t;

    // Entry contents. The valid bit lives in a separate vector so it can be
    // reset on its own while the data fields are left unreset.
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        iq_src_t              src1;
        iq_src_t              src2;
    } iq_entry_t;

    // True when any valid broadcast lane carries the given tag.
    function automatic logic tag_hit(
        input logic [TAG_W-1:0]       tag,
        input logic [LANES-1:0]       wb_valid,
        input logic [LANES*TAG_W-1:0] wb_tag
    );
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (wb_valid[l] && (wb_tag[l*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Source after snooping this cycle's broadcasts; readiness is sticky.
    function automatic iq_src_t wake_src(
        input iq_src_t                src,
        input logic [LANES-1:0]       wb_valid,
        input logic [LANES*TAG_W-1:0] wb_tag
    );
        iq_src_t woken;
        woken     = src;
        woken.rdy = src.rdy | tag_hit(src.tag, wb_valid, wb_tag);
        return woken;
    endfunction

endpackage

// File: rtl/iq_free_finder.sv
// Lowest-index free slot finder: priority encoder over the inverted valid bits.
module iq_free_finder
    import issue_queue_pkg::*;
(
    input  logic [DEPTH-1:0] valid,
    output logic [IDX_W-1:0] free_idx,
    output logic             any_free
);

    // Scan from the top down so the lowest empty slot is the last to win.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// 16-entry out-of-order issue queue: dispatch into the lowest free slot, snoop
// two result-tag buses for wakeup, raise requests to the selector and register
// the granted payload toward execute.
module issue_queue
    import issue_queue_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   flush_IN,
    input  logic                   dispatch_valid_IN,
    output logic                   dispatch_ready_OUT,
    input  logic [PAYLOAD_W-1:0]   dispatch_payload_IN,
    input  logic [TAG_W-1:0]       dispatch_src1_tag_IN,
    input  logic [TAG_W-1:0]       dispatch_src2_tag_IN,
    input  logic                   dispatch_src1_rdy_IN,
    input  logic                   dispatch_src2_rdy_IN,
    input  logic [LANES-1:0]       wb_valid_IN,
    input  logic [LANES*TAG_W-1:0] wb_tag_IN,
    output logic [DEPTH-1:0]       request_OUT,
    input  logic                   Issue_IN,
    input  logic [IDX_W-1:0]       grant_index_IN,
    input  logic                   exec_stall_IN,
    output logic                   issue_valid_OUT,
    output logic [PAYLOAD_W-1:0]   issue_payload_OUT,
    output logic [CNT_W-1:0]       count_OUT
);

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     valid_n;
    iq_entry_t            entry_q [DEPTH];
    iq_entry_t            entry_n [DEPTH];
    iq_entry_t            disp_entry;
    logic [IDX_W-1:0]     free_idx;
    logic                 any_free;
    logic                 grant_valid;
    logic                 dispatch_fire;
    logic                 issue_fire;
    logic [CNT_W-1:0]     count_q;
    logic                 issue_valid_p1;
    logic [PAYLOAD_W-1:0] issue_payload_p1;

    iq_free_finder u_free_finder (
        .valid    (valid_q),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    // Readiness looks only at pre-edge valid bits, so a slot freed by this
    // cycle's issue cannot be refilled until the following cycle.
    assign dispatch_ready_OUT = any_free;
    assign grant_valid        = valid_q[grant_index_IN];
    assign dispatch_fire      = dispatch_valid_IN & any_free & ~flush_IN;
    assign issue_fire         = Issue_IN & ~exec_stall_IN & grant_valid & ~flush_IN;

    assign issue_valid_OUT    = issue_valid_p1;
    assign issue_payload_OUT  = issue_payload_p1;
    assign count_OUT          = count_q;

    // Request every valid entry with both operands ready; a stalled execute
    // stage masks all requests so the selector stays quiet.
    always_comb begin
        request_OUT = '0;
        for (int i = 0; i < DEPTH; i++) begin
            request_OUT[i] = valid_q[i] & entry_q[i].src1.rdy &
                             entry_q[i].src2.rdy & ~exec_stall_IN;
        end
    end

    // Build the incoming entry, bypassing same-cycle broadcasts into its rdy bits.
    always_comb begin
        disp_entry.payload  = dispatch_payload_IN;
        disp_entry.src1.tag = dispatch_src1_tag_IN;
        disp_entry.src1.rdy = dispatch_src1_rdy_IN;
        disp_entry.src2.tag = dispatch_src2_tag_IN;
        disp_entry.src2.rdy = dispatch_src2_rdy_IN;
        disp_entry.src1     = wake_src(disp_entry.src1, wb_valid_IN, wb_tag_IN);
        disp_entry.src2     = wake_src(disp_entry.src2, wb_valid_IN, wb_tag_IN);
    end

    // Next entry contents: wake resident operands, then overlay the dispatch slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_n[i] = entry_q[i];
            if (valid_q[i]) begin
                entry_n[i].src1 = wake_src(entry_q[i].src1, wb_valid_IN, wb_tag_IN);
                entry_n[i].src2 = wake_src(entry_q[i].src2, wb_valid_IN, wb_tag_IN);
            end
            if (dispatch_fire && (free_idx == IDX_W'(i))) begin
                entry_n[i] = disp_entry;
            end
        end
    end

    // Next valid vector: flush clears everything, otherwise free the granted
    // slot and claim the dispatch slot (never the same slot, since the grant
    // must point at a valid entry and dispatch only targets an empty one).
    always_comb begin
        valid_n = valid_q;
        if (flush_IN) begin
            valid_n = '0;
        end else begin
            if (issue_fire) begin
                valid_n[grant_index_IN] = 1'b0;
            end
            if (dispatch_fire) begin
                valid_n[free_idx] = 1'b1;
            end
        end
    end

    // Entry data registers; contents of empty slots are don't-care, so no reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= entry_n[i];
        end
    end

    // Occupancy, valid bits and the issue register toward execute.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q          <= '0;
            count_q          <= '0;
            issue_valid_p1   <= 1'b0;
            issue_payload_p1 <= '0;
        end else begin
            valid_q <= valid_n;
            if (flush_IN) begin
                count_q        <= '0;
                issue_valid_p1 <= 1'b0;
            end else begin
                count_q <= count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
                if (!exec_stall_IN) begin
                    issue_valid_p1 <= issue_fire;
                    if (issue_fire) begin
                        issue_payload_p1 <= entry_q[grant_index_IN].payload;
                    end
                end
            end
        end
    end

    // Catch a selector grant aimed at an empty slot; the grant itself is dropped.
    always_ff @(posedge CLK) begin
        if (RESET && Issue_IN && !exec_stall_IN && !flush_IN) begin
            assert (grant_valid);
        end
    end

endmodule
